// File: rtl/seven_segment_four_bit_counter.sv
// Prescaled 4-bit counter shown as "00".."15" on two digits of a multiplexed common-anode display.
// Decode is combinational from registered count/sel (zero latency); no flow control, free-running.
module seven_segment_four_bit_counter #(
    parameter int unsigned TICK_DIV = 100_000_000,
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic       clck,
    input  logic       reset,
    output logic [6:0] a_to_g,
    output logic [7:0] Anode_Activate,
    output logic       dp
);
    localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

    logic [1:0]    rst_sync_q;
    logic          rst_n;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [SW-1:0] scan_cnt_q, scan_cnt_d;
    logic [3:0]    count_q, count_d;
    logic          sel_q, sel_d;
    logic          tick, scan;
    logic [3:0]    ones, tens, digit;

    // Assert passes straight through; release is delayed two edges.
    always_ff @(posedge clck or negedge reset) begin
        if (!reset) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    always_comb begin
        tick       = (tick_cnt_q == TICK_MAX);
        scan       = (scan_cnt_q == SCAN_MAX);
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
        scan_cnt_d = scan ? '0 : scan_cnt_q + 1'b1;
        count_d    = count_q + {3'b000, tick};
        sel_d      = sel_q ^ scan;
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            count_q    <= 4'd0;
            sel_q      <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            count_q    <= count_d;
            sel_q      <= sel_d;
        end
    end

    always_comb begin
        ones  = (count_q >= 4'd10) ? count_q - 4'd10 : count_q;
        tens  = {3'b000, (count_q >= 4'd10)};
        digit = sel_q ? tens : ones;
        Anode_Activate = sel_q ? 8'b1111_1101 : 8'b1111_1110;
        dp = 1'b1;
        case (digit)
            4'd0:    a_to_g = 7'b000_0001;
            4'd1:    a_to_g = 7'b100_1111;
            4'd2:    a_to_g = 7'b001_0010;
            4'd3:    a_to_g = 7'b000_0110;
            4'd4:    a_to_g = 7'b100_1100;
            4'd5:    a_to_g = 7'b010_0100;
            4'd6:    a_to_g = 7'b010_0000;
            4'd7:    a_to_g = 7'b000_1111;
            4'd8:    a_to_g = 7'b000_0000;
            4'd9:    a_to_g = 7'b000_0100;
            default: a_to_g = 7'b111_1111;
        endcase
    end
endmodule

// File: tb/tb_seven_segment_four_bit_counter.sv
// Bench: five parameterisations share clock and a randomly pulsed reset; outputs compared to an arithmetic model.
module tb_seven_segment_four_bit_counter;
    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NI-1:0][6:0] seg;
    logic [NI-1:0][7:0] an;
    logic [NI-1:0]      dpw;

    int errors = 0;
    int checks = 0;
    int e      = 0;

    always #5 clk = ~clk;

    seven_segment_four_bit_counter #(.TICK_DIV(4), .SCAN_DIV(1000)) u0 (.clck(clk), .reset(rst), .a_to_g(seg[0]), .Anode_Activate(an[0]), .dp(dpw[0]));
    seven_segment_four_bit_counter #(.TICK_DIV(2), .SCAN_DIV(1))    u1 (.clck(clk), .reset(rst), .a_to_g(seg[1]), .Anode_Activate(an[1]), .dp(dpw[1]));
    seven_segment_four_bit_counter #(.TICK_DIV(3), .SCAN_DIV(3))    u2 (.clck(clk), .reset(rst), .a_to_g(seg[2]), .Anode_Activate(an[2]), .dp(dpw[2]));
    seven_segment_four_bit_counter #(.TICK_DIV(1), .SCAN_DIV(7))    u3 (.clck(clk), .reset(rst), .a_to_g(seg[3]), .Anode_Activate(an[3]), .dp(dpw[3]));
    seven_segment_four_bit_counter                                  u4 (.clck(clk), .reset(rst), .a_to_g(seg[4]), .Anode_Activate(an[4]), .dp(dpw[4]));

    // Rising edges seen since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) e <= 0;
        else      e <= e + 1;
    end

    function automatic int td_of(int i);
        case (i)
            0: return 4;
            1: return 2;
            2: return 3;
            3: return 1;
            default: return 100_000_000;
        endcase
    endfunction

    function automatic int sd_of(int i);
        case (i)
            0: return 1000;
            1: return 1;
            2: return 3;
            3: return 7;
            default: return 100_000;
        endcase
    endfunction

    function automatic logic [6:0] seg_code(int d);
        logic [6:0] tbl [10];
        tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
        return tbl[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: after the two synchroniser edges, the n-th active edge has advanced count n/TICK_DIV times.
    task automatic check_all(input bit in_reset);
        int n, cnt, sel, d;
        for (int i = 0; i < NI; i++) begin
            n   = (in_reset || e <= 2) ? 0 : e - 2;
            cnt = (n / td_of(i)) % 16;
            sel = (n / sd_of(i)) % 2;
            d   = sel ? cnt / 10 : cnt % 10;
            chk($sformatf("seg%0d", i),   32'(seg[i]), 32'(seg_code(d)));
            chk($sformatf("anode%0d", i), 32'(an[i]),  sel ? 32'hFD : 32'hFE);
            chk($sformatf("dp%0d", i),    32'(dpw[i]), 32'd1);
        end
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 check_all(1'b1);
        repeat (3) begin
            @(negedge clk);
            check_all(1'b1);
        end
        rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check_all(1'b0);
            if ($urandom_range(0, 199) == 0) begin
                // Mid-cycle assert: outputs must reset before any clock edge.
                #2 rst = 1'b0;
                #1 check_all(1'b1);
                repeat ($urandom_range(1, 5)) begin
                    @(negedge clk);
                    check_all(1'b1);
                end
                rst = 1'b1;
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
